// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit bus receiver.
// Holds the FSM encoding, command opcodes, buffer geometry and DDRAM line bases.
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_INIT8 = 2'd0,
        ST_HI    = 2'd1,
        ST_LO    = 2'd2
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;

    localparam int         BUF_DEPTH  = 32;
    localparam logic [7:0] BLANK_CHAR = 8'h20;
    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;

    // Buffer index 0..15 is line 0, 16..31 is line 1.
    function automatic logic [6:0] ddram_addr(input logic [4:0] cur);
        return (cur[4] ? LINE1_BASE : LINE0_BASE) + {3'b000, cur[3:0]};
    endfunction

endpackage

// File: rtl/lcd_sync.sv
// Double-flop synchroniser for the asynchronous LCD bus, with a falling-edge
// detector on E; data and E are flopped in parallel so they stay aligned.
module lcd_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             e_async,
    input  logic [WIDTH-1:0] d_async,
    output logic             e_fall,
    output logic [WIDTH-1:0] d_sync
);

    logic             e_meta;
    logic             e_sync;
    logic             e_prev;
    logic [WIDTH-1:0] d_meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_meta <= 1'b0;
            e_sync <= 1'b0;
            e_prev <= 1'b0;
            d_meta <= '0;
            d_sync <= '0;
        end else begin
            e_meta <= e_async;
            e_sync <= e_meta;
            e_prev <= e_sync;
            d_meta <= d_async;
            d_sync <= d_meta;
        end
    end

    assign e_fall = e_prev & ~e_sync;

endmodule

// File: rtl/lcd_receiver.sv
// HD44780 4-bit bus receiver: assembles nibbles into bytes, emulates the
// busy flag and address counter, and keeps a 32-entry character buffer.
//
// state | meaning
// INIT8 | waiting for the 0x3.. 0x2 wake-up nibbles that enter 4-bit mode
// HI    | next bus event carries the high nibble (or first read nibble)
// LO    | next bus event carries the low nibble (or second read nibble)
module lcd_receiver
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 80000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_nibble,
    output logic [3:0] lcd_dout,
    output logic       byte_valid,
    output logic       byte_rs,
    output logic [7:0] byte_data,
    output logic [4:0] cursor,
    output logic       busy,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       mode4,
    output logic       protocol_err
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    lcd_state_t state, state_next;

    logic             e_fall;
    logic [5:0]       bus_s;
    logic             rs_s, rw_s;
    logic [3:0]       nib_s;
    logic [3:0]       hi_nib;
    logic             hi_rw;
    logic             dir_inc;
    logic [CNT_W-1:0] busy_cnt;
    logic [7:0]       buffer [BUF_DEPTH];

    logic       set_mode4, fsm_err, latch_hi, byte_done;
    logic [7:0] byte_asm;
    logic       is_clear, is_home, is_entry, is_ddram, is_data, ddram_ok;
    logic       err_any;
    logic [6:0] cur_dd;

    lcd_sync #(.WIDTH(6)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .e_async (lcd_e),
        .d_async ({lcd_rs, lcd_rw, lcd_nibble}),
        .e_fall  (e_fall),
        .d_sync  (bus_s)
    );

    assign rs_s     = bus_s[5];
    assign rw_s     = bus_s[4];
    assign nib_s    = bus_s[3:0];
    assign byte_asm = {hi_nib, nib_s};
    assign busy     = (busy_cnt != '0);
    assign cur_dd   = ddram_addr(cursor);
    assign rd_char  = buffer[rd_addr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_INIT8;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        set_mode4  = 1'b0;
        fsm_err    = 1'b0;
        latch_hi   = 1'b0;
        byte_done  = 1'b0;
        if (e_fall) begin
            case (state)
                ST_INIT8: begin
                    if (rw_s)                fsm_err = 1'b1;
                    else if (nib_s == 4'h2) begin
                        set_mode4  = 1'b1;
                        state_next = ST_HI;
                    end else if (nib_s != 4'h3) fsm_err = 1'b1;
                end
                ST_HI: begin
                    latch_hi   = 1'b1;
                    state_next = ST_LO;
                    if (rw_s && rs_s) fsm_err = 1'b1;
                end
                ST_LO: begin
                    // A rw flip mid-byte drops the byte and realigns on HI.
                    state_next = ST_HI;
                    if (rw_s != hi_rw)  fsm_err   = 1'b1;
                    else if (!rw_s)     byte_done = 1'b1;
                    else if (rs_s)      fsm_err   = 1'b1;
                end
                default: state_next = ST_INIT8;
            endcase
        end
    end

    always_comb begin
        is_data  = byte_done && rs_s;
        is_clear = byte_done && !rs_s && (byte_asm == CMD_CLEAR);
        is_home  = byte_done && !rs_s && (byte_asm[7:1] == CMD_HOME[7:1]);
        is_entry = byte_done && !rs_s && (byte_asm[7:2] == CMD_ENTRY[7:2]);
        is_ddram = byte_done && !rs_s && (byte_asm[7] == CMD_SET_DDRAM[7]);
        ddram_ok = (byte_asm[6:4] == LINE0_BASE[6:4]) || (byte_asm[6:4] == LINE1_BASE[6:4]);
        err_any  = fsm_err || (byte_done && busy) || (is_ddram && !ddram_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_nib       <= 4'h0;
            hi_rw        <= 1'b0;
            mode4        <= 1'b0;
            protocol_err <= 1'b0;
            byte_valid   <= 1'b0;
            byte_rs      <= 1'b0;
            byte_data    <= 8'h00;
            cursor       <= 5'd0;
            dir_inc      <= 1'b1;
            busy_cnt     <= '0;
        end else begin
            byte_valid <= byte_done;
            if (latch_hi) begin
                hi_nib <= nib_s;
                hi_rw  <= rw_s;
            end
            if (set_mode4) mode4 <= 1'b1;
            if (err_any)   protocol_err <= 1'b1;
            if (byte_done) begin
                byte_rs   <= rs_s;
                byte_data <= byte_asm;
            end
            if (is_clear || is_home)     cursor <= 5'd0;
            else if (is_ddram && ddram_ok) cursor <= {byte_asm[6], byte_asm[3:0]};
            else if (is_data)            cursor <= dir_inc ? cursor + 5'd1 : cursor - 5'd1;
            if (is_clear)      dir_inc <= 1'b1;
            else if (is_entry) dir_inc <= byte_asm[1];
            if (byte_done)     busy_cnt <= is_clear ? CNT_W'(CLEAR_CYCLES) : CNT_W'(BUSY_CYCLES);
            else if (busy)     busy_cnt <= busy_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= BLANK_CHAR;
        end else if (is_clear) begin
            for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= BLANK_CHAR;
        end else if (is_data) begin
            buffer[cursor] <= byte_asm;
        end
    end

    // Status read-back follows the synchronised bus so it is ready before E falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  lcd_dout <= 4'h0;
        else if (rw_s && !rs_s && state == ST_HI)  lcd_dout <= {busy, cur_dd[6:4]};
        else if (rw_s && !rs_s && state == ST_LO)  lcd_dout <= cur_dd[3:0];
        else                                       lcd_dout <= 4'h0;
    end

endmodule

// File: tb/tb_lcd_receiver.sv
// Directed bench for lcd_receiver: init, addressing table, busy timing,
// clear, read-back and error/reset corner cases.
module tb_lcd_receiver;

    localparam int BUSY  = 40;
    localparam int CLEAR = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_e, lcd_rs, lcd_rw;
    logic [3:0] lcd_nibble;
    logic [3:0] lcd_dout;
    logic       byte_valid, byte_rs;
    logic [7:0] byte_data;
    logic [4:0] cursor;
    logic       busy;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic       mode4, protocol_err;

    int n_pass  = 0;
    int n_total = 0;
    int bv_cnt  = 0;

    lcd_receiver #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
        .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_nibble(lcd_nibble), .lcd_dout(lcd_dout), .byte_valid(byte_valid),
        .byte_rs(byte_rs), .byte_data(byte_data), .cursor(cursor), .busy(busy),
        .rd_addr(rd_addr), .rd_char(rd_char), .mode4(mode4), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (byte_valid) bv_cnt++;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [4:0] cur;
        logic [4:0] addr;
        logic [7:0] ch;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bus_event(input logic rs, input logic rw, input logic [3:0] nib);
        lcd_rs = rs; lcd_rw = rw; lcd_nibble = nib;
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Returns at the negedge where byte_valid is high.
    task automatic send_byte(input logic rs, input logic [7:0] b, output bit seen);
        bus_event(rs, 1'b0, b[7:4]);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_nibble = b[3:0];
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        lcd_e = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (byte_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_nib(input logic rs, output logic [3:0] nib);
        lcd_rs = rs; lcd_rw = 1'b1; lcd_nibble = 4'h0;
        lcd_e = 1'b1;
        repeat (4) @(negedge clk);
        nib = lcd_dout;
        lcd_e = 1'b0;
        repeat (4) @(negedge clk);
        lcd_rw = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 1000) begin
            k++;
            @(negedge clk);
        end
        chk("wait_idle", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_init();
        bus_event(1'b0, 1'b0, 4'h3);
        bus_event(1'b0, 1'b0, 4'h3);
        bus_event(1'b0, 1'b0, 4'h3);
        bus_event(1'b0, 1'b0, 4'h2);
    endtask

    initial begin
        bit         seen;
        int         n;
        int         bv_before;
        logic [3:0] nib;

        vecs[0]  = '{1'b0, 8'hC0, 5'd16, 5'd0,  8'h41};
        vecs[1]  = '{1'b1, 8'h5A, 5'd17, 5'd16, 8'h5A};
        vecs[2]  = '{1'b0, 8'h8F, 5'd15, 5'd16, 8'h5A};
        vecs[3]  = '{1'b0, 8'h04, 5'd15, 5'd15, 8'h20};
        vecs[4]  = '{1'b1, 8'h42, 5'd14, 5'd15, 8'h42};
        vecs[5]  = '{1'b0, 8'h80, 5'd0,  5'd0,  8'h41};
        vecs[6]  = '{1'b1, 8'h33, 5'd31, 5'd0,  8'h33};
        vecs[7]  = '{1'b0, 8'h06, 5'd31, 5'd31, 8'h20};
        vecs[8]  = '{1'b1, 8'h44, 5'd0,  5'd31, 8'h44};
        vecs[9]  = '{1'b1, 8'h45, 5'd1,  5'd0,  8'h45};
        vecs[10] = '{1'b0, 8'h03, 5'd0,  5'd0,  8'h45};
        vecs[11] = '{1'b0, 8'h4F, 5'd0,  5'd1,  8'h20};
        vecs[12] = '{1'b0, 8'hCF, 5'd31, 5'd31, 8'h44};
        vecs[13] = '{1'b0, 8'h05, 5'd31, 5'd30, 8'h20};

        rst = 1'b0; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_nibble = 4'h0;
        rd_addr = 5'd5;
        repeat (3) @(negedge clk);
        chk("rst_mode4", mode4, 0);
        chk("rst_err", protocol_err, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dout", lcd_dout, 0);
        chk("rst_byte_valid", byte_valid, 0);
        chk("rst_buf", rd_char, 8'h20);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_init();
        chk("init_mode4", mode4, 1);
        chk("init_err", protocol_err, 0);

        send_byte(1'b1, 8'h41, seen);
        chk("w41_seen", seen, 1);
        chk("w41_data", byte_data, 8'h41);
        chk("w41_rs", byte_rs, 1);
        count_busy(n);
        chk("w41_busy_len", n, BUSY);
        rd_addr = 5'd0;
        #1;
        chk("w41_buf0", rd_char, 8'h41);
        chk("w41_cursor", cursor, 1);

        foreach (vecs[i]) begin
            send_byte(vecs[i].rs, vecs[i].data, seen);
            chk($sformatf("vec%0d_data", i), {seen, byte_data}, {1'b1, vecs[i].data});
            wait_idle();
            rd_addr = vecs[i].addr;
            #1;
            chk($sformatf("vec%0d_cursor", i), cursor, vecs[i].cur);
            chk($sformatf("vec%0d_char", i), rd_char, vecs[i].ch);
            chk($sformatf("vec%0d_err", i), protocol_err, 0);
        end

        // Busy poll: cursor 17 maps to DDRAM 0x41.
        send_byte(1'b0, 8'hC1, seen);
        read_nib(1'b0, nib);
        chk("poll_busy_hi", nib, 4'hC);
        read_nib(1'b0, nib);
        chk("poll_busy_lo", nib, 4'h1);
        wait_idle();
        read_nib(1'b0, nib);
        chk("poll_idle_hi", nib, 4'h4);
        read_nib(1'b0, nib);
        chk("poll_idle_lo", nib, 4'h1);
        chk("poll_err", protocol_err, 0);

        send_byte(1'b0, 8'h01, seen);
        chk("clr_seen", {seen, byte_rs, byte_data}, {1'b1, 1'b0, 8'h01});
        count_busy(n);
        chk("clr_busy_len", n, CLEAR);
        chk("clr_cursor", cursor, 0);
        for (int a = 0; a < 32; a++) begin
            rd_addr = 5'(a);
            #1;
            chk($sformatf("clr_buf%0d", a), rd_char, 8'h20);
        end

        // Second byte lands while busy; clear restored increment direction.
        send_byte(1'b1, 8'h61, seen);
        send_byte(1'b1, 8'h62, seen);
        chk("busyw_err", protocol_err, 1);
        chk("busyw_cursor", cursor, 2);
        rd_addr = 5'd1;
        #1;
        chk("busyw_buf1", rd_char, 8'h62);

        wait_idle();
        bus_event(1'b1, 1'b0, 4'h4);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rd_addr = 5'd0;
        #1;
        chk("mid_rst_mode4", mode4, 0);
        chk("mid_rst_err", protocol_err, 0);
        chk("mid_rst_cursor", cursor, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bdata", {byte_valid, byte_rs, byte_data}, 0);
        chk("mid_rst_buf0", rd_char, 8'h20);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bv_before = bv_cnt;
        bus_event(1'b1, 1'b0, 4'h1);
        chk("post_rst_init_err", protocol_err, 1);
        chk("post_rst_no_byte", bv_cnt, bv_before);
        chk("post_rst_mode4", mode4, 0);

        do_reset();
        do_init();
        send_byte(1'b0, 8'h85, seen);
        wait_idle();
        chk("addr85_cursor", cursor, 5);
        chk("addr85_err", protocol_err, 0);
        send_byte(1'b0, 8'h90, seen);
        wait_idle();
        chk("addr90_err", protocol_err, 1);
        chk("addr90_cursor", cursor, 5);

        do_reset();
        do_init();
        bus_event(1'b0, 1'b0, 4'h8);
        read_nib(1'b0, nib);
        chk("rwchg_err", protocol_err, 1);
        send_byte(1'b0, 8'h87, seen);
        wait_idle();
        chk("rwchg_resync", cursor, 7);

        do_reset();
        do_init();
        read_nib(1'b1, nib);
        chk("rsread_dout", nib, 0);
        chk("rsread_err", protocol_err, 1);

        do_reset();
        read_nib(1'b0, nib);
        chk("init_read_dout", nib, 0);
        chk("init_read_err", protocol_err, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lcd_receiver.md
LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 Parameter BUSY_CYCLES, default 2000: clk cycles the busy flag stays set after each accepted byte.
REQ-002 Parameter CLEAR_CYCLES, default 80000: clk cycles the busy flag stays set after a Clear Display command.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 lcd_e, lcd_rs, lcd_rw  in  1 each  HD44780 4-bit bus strobe, register select and read/write, asynchronous to clk.
REQ-006 lcd_nibble  in  4  bus data from the controller.
REQ-007 lcd_dout  out  4  read-back nibble; valid only while lcd_rw=1.
REQ-008 byte_valid  out  1  one-cycle pulse per assembled byte; byte_rs  out  1 and byte_data  out  8 qualify it.
REQ-009 cursor  out  5  current buffer address, 0..31.
REQ-010 busy  out  1  emulated busy flag.
REQ-011 rd_addr  in  5, rd_char  out  8  combinational read port into the display buffer.
REQ-012 mode4  out  1  set once 4-bit mode is entered; protocol_err  out  1  sticky error.

Function
REQ-013 lcd_e, lcd_rs, lcd_rw and lcd_nibble are each double-flop synchronised; a falling edge of synchronised E (previous=1, current=0) is the sample event, and rs, rw and nibble are taken from the same synchronised cycle.
REQ-014 FSM states: INIT8, HI, LO.
REQ-015 INIT8: a write event with nibble 0x3 stays in INIT8; nibble 0x2 sets mode4=1 and enters HI; any other nibble sets protocol_err and stays in INIT8.
REQ-016 HI: a write event latches the nibble as byte[7:4] and enters LO; LO: a write event forms byte = {hi, nibble}, pulses byte_valid the next cycle with byte_rs=rs from the LO event, and returns to HI.
REQ-017 rs=1 byte: buffer[cursor] <= byte; cursor steps +1 or -1 per the entry-mode bit, wrapping 31->0 and 0->31.
REQ-018 rs=0 byte decode: 0x01 fills all 32 entries with 0x20 in one cycle, sets cursor=0 and sets direction=increment; 0x02 or 0x03 sets cursor=0; 0x04..0x07 sets direction from bit1 (1=increment); 0x80|a maps a=0x00..0x0F to 0..15 and a=0x40..0x4F to 16..31, and any other a sets protocol_err with cursor unchanged; all other codes are accepted and ignored.
REQ-019 Every accepted byte loads a busy counter with BUSY_CYCLES, or with CLEAR_CYCLES for 0x01; busy = (counter != 0); the counter decrements by 1 per clk and saturates at 0.
REQ-020 A write byte completed while busy=1 is still executed and sets protocol_err.
REQ-021 Read (rw=1, rs=0) in HI or LO: lcd_dout = {busy, cursor_ddram[6:4]} in HI and cursor_ddram[3:0] in LO. cursor_ddram is 0x00+cursor for cursor<16 and 0x40+(cursor-16) otherwise. The read falling edge toggles HI/LO and causes no buffer or cursor change.
REQ-022 A read with rs=1, or any read in INIT8, drives lcd_dout=0 and sets protocol_err.
REQ-023 A rw change between the HI and LO events of one byte sets protocol_err and resynchronises to HI.
REQ-024 Simultaneous clear and write cannot occur, because events are serialised by E.

Reset
REQ-025 While rst=0: state=INIT8, mode4=0, cursor=0, direction=increment, busy counter=0, byte_valid=0, byte_rs=0, byte_data=0, lcd_dout=0, protocol_err=0, all buffer entries=0x20, synchronisers=0.
REQ-026 Reset asserted mid-byte discards the half-assembled nibble; the first post-reset event is treated as INIT8.

Structure
REQ-027 Shared package lcd_pkg: state enumeration, command opcodes (CLEAR, HOME, ENTRY, SET_DDRAM), buffer depth 32, blank character 0x20, and line base addresses 0x00 and 0x40.
REQ-028 One sub-module, lcd_sync: a parameterised-width double-flop synchroniser with E falling-edge detect; the FSM, decoder, busy counter and 32x8 register buffer reside in lcd_receiver.

Verification
REQ-029 Init sequence: nibbles 0x3, 0x3, 0x3, 0x2 -> mode4=1, state HI, protocol_err=0.
REQ-030 Write sequence: rs=1 nibbles 0x4, 0x1 -> byte_valid pulse with byte_data=0x41; buffer[0]=0x41; cursor=1; busy high for exactly BUSY_CYCLES.
REQ-031 Addressing: command 0xC0, then data 0x5A -> buffer[16]=0x5A; cursor=17. Command 0x8F, then data 0x42 with entry mode 0x04 -> buffer[15]=0x42, cursor=14. With cursor=0 and direction decrement, a write -> cursor=31.
REQ-032 Clear: command 0x01 after writes -> all rd_char reads return 0x20, cursor=0, busy held CLEAR_CYCLES.
REQ-033 Busy poll: read rs=0 immediately after a write -> first nibble has MSB 1; after busy drops -> MSB 0, and the low 3 bits plus the second nibble equal cursor_ddram.
REQ-034 Errors and reset: command 0x90 -> protocol_err=1 with cursor unchanged; rst pulsed low after one nibble in HI -> all REQ-025 values restored, then the init sequence is required again.
